// File: rtl/uart_cmd_exec.sv
// rtl/uart_cmd_exec.sv - parses a received UART line in shared RAM and writes the response string.
// Optional 'L' (hex length) opcode is enabled by defining UART_CMD_LEN_EN.
module uart_cmd_exec #(
  parameter int WIDTH      = 8,
  parameter int LEN        = 256,
  parameter int RXSTR_BASE = 0,
  parameter int TXSTR_BASE = 128,
  localparam int AW        = $clog2(LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [AW-1:0]    cmd_len,
  output logic             msg_valid,
  output logic [AW-1:0]    msg_len,
  output logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] dout,
  output logic             we
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP_RD,
    S_OP_DEC,
    S_EXEC,
    S_CR,
    S_LF,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] RX_A = AW'(RXSTR_BASE);
  localparam logic [AW-1:0] TX_A = AW'(TXSTR_BASE);
  localparam logic [AW-1:0] CAP  = AW'(LEN - TXSTR_BASE - 2);

  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_U  = 8'h55;
  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_Q  = 8'h3F;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

`ifdef UART_CMD_LEN_EN
  localparam bit LEN_OP_EN = 1'b1;
`else
  localparam bit LEN_OP_EN = 1'b0;
`endif

  state_t          state_q, state_d;
  logic [AW-1:0]   n_q, n_d;
  logic [AW-1:0]   m_q, m_d;
  logic [AW-1:0]   i_q, i_d;
  logic [AW-1:0]   k_q, k_d;
  logic [AW-1:0]   msg_len_q, msg_len_d;
  logic [7:0]      op_q, op_d;
  logic            phase_q, phase_d;

  logic [AW-1:0]   addr_c;
  logic [7:0]      wdat_c;
  logic            we_c;
  logic            msg_valid_c;
  logic [AW-1:0]   n_in;

  function automatic logic [7:0] xform(input logic [7:0] op, input logic [7:0] b);
    if (op == CH_U && b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    return b;
  endfunction

`ifdef UART_CMD_LEN_EN
  logic [7:0] n8;
  assign n8 = 8'(n_q);

  function automatic logic [7:0] hex_digit(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
  endfunction
`endif

  // Payload length excludes the op byte and the terminator, floored at zero.
  assign n_in = (cmd_len > AW'(1)) ? (cmd_len - AW'(2)) : '0;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    m_d         = m_q;
    i_d         = i_q;
    k_d         = k_q;
    op_d        = op_q;
    phase_d     = phase_q;
    msg_len_d   = msg_len_q;
    addr_c      = '0;
    wdat_c      = '0;
    we_c        = 1'b0;
    msg_valid_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          n_d     = n_in;
          m_d     = (n_in > CAP) ? CAP : n_in;
          i_d     = '0;
          k_d     = '0;
          phase_d = 1'b0;
          state_d = (cmd_len > AW'(1)) ? S_OP_RD : S_CR;
        end
      end

      S_OP_RD: begin
        addr_c  = RX_A;
        state_d = S_OP_DEC;
      end

      S_OP_DEC: begin
        op_d = dout[7:0];
        if (dout[7:0] == CH_E || dout[7:0] == CH_R || dout[7:0] == CH_U) begin
          state_d = (m_q == '0) ? S_CR : S_EXEC;
        end else if (LEN_OP_EN && dout[7:0] == CH_L) begin
          state_d = S_EXEC;
        end else begin
          addr_c  = TX_A;
          wdat_c  = CH_Q;
          we_c    = 1'b1;
          k_d     = k_q + AW'(1);
          state_d = S_CR;
        end
      end

      S_EXEC: begin
`ifdef UART_CMD_LEN_EN
        if (op_q == CH_L) begin
          addr_c = TX_A + k_q;
          wdat_c = hex_digit(k_q[0] ? n8[3:0] : n8[7:4]);
          we_c   = 1'b1;
          k_d    = k_q + AW'(1);
          if (k_q[0]) state_d = S_CR;
        end else
`endif
        // Read phase addresses the payload byte; write phase stores it one cycle later.
        if (!phase_q) begin
          addr_c  = RX_A + AW'(1) + ((op_q == CH_R) ? (n_q - AW'(1) - i_q) : i_q);
          phase_d = 1'b1;
        end else begin
          addr_c  = TX_A + k_q;
          wdat_c  = xform(op_q, dout[7:0]);
          we_c    = 1'b1;
          k_d     = k_q + AW'(1);
          i_d     = i_q + AW'(1);
          phase_d = 1'b0;
          if (i_q + AW'(1) == m_q) state_d = S_CR;
        end
      end

      S_CR: begin
        addr_c  = TX_A + k_q;
        wdat_c  = CH_CR;
        we_c    = 1'b1;
        k_d     = k_q + AW'(1);
        state_d = S_LF;
      end

      S_LF: begin
        addr_c    = TX_A + k_q;
        wdat_c    = CH_LF;
        we_c      = 1'b1;
        msg_len_d = k_q + AW'(1);
        state_d   = S_DONE;
      end

      S_DONE: begin
        msg_valid_c = 1'b1;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      m_q       <= '0;
      i_q       <= '0;
      k_q       <= '0;
      op_q      <= '0;
      phase_q   <= 1'b0;
      msg_len_q <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      m_q       <= m_d;
      i_q       <= i_d;
      k_q       <= k_d;
      op_q      <= op_d;
      phase_q   <= phase_d;
      msg_len_q <= msg_len_d;
    end
  end

  assign addr      = addr_c;
  assign din       = WIDTH'(wdat_c);
  assign we        = we_c;
  assign msg_valid = msg_valid_c;
  assign msg_len   = msg_len_q;

endmodule

// File: tb/tb_uart_cmd_exec.sv
// tb/tb_uart_cmd_exec.sv - self-checking bench for uart_cmd_exec with a shared RAM model.
// Expected 'L' behaviour follows UART_CMD_LEN_EN.
module tb_uart_cmd_exec;
  localparam int AW = 8;
  localparam int TX = 128;
  localparam int CAPN = 126;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [63:0] line;
    int          clen;
    logic [63:0] exp;
    int          elen;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [AW-1:0] cmd_len = '0;
  logic          msg_valid;
  logic [AW-1:0] msg_len;
  logic [AW-1:0] addr;
  logic [7:0]    din;
  logic [7:0]    dout = '0;
  logic          we;

  logic          tb_we = 1'b0;
  logic [7:0]    tb_addr = '0;
  logic [7:0]    tb_din = '0;
  logic [7:0]    mem [256];

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int low_wr = 0;

  bq_t  line_q;
  bq_t  exp_q;
  vec_t vt[11];

  uart_cmd_exec dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_len(cmd_len),
    .msg_valid(msg_valid), .msg_len(msg_len), .addr(addr), .din(din),
    .dout(dout), .we(we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_din;
    else if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

  always @(negedge clk) begin
    if (!rst && msg_valid) pulses++;
    if (!rst && we && addr < 8'd128) low_wr++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic ram_wr(input int a, input logic [7:0] d);
    tb_addr = 8'(a);
    tb_din  = d;
    tb_we   = 1'b1;
    @(negedge clk);
    tb_we   = 1'b0;
  endtask

  function automatic bq_t str2q(input logic [63:0] s, input int len);
    bq_t q;
    q = {};
    for (int j = 0; j < len; j++) q.push_back(s[8*(len-1-j) +: 8]);
    return q;
  endfunction

`ifdef UART_CMD_LEN_EN
  function automatic logic [7:0] hexc(input int v);
    return (v < 10) ? (8'h30 + 8'(v)) : (8'h41 + 8'(v - 10));
  endfunction
`endif

  // Reference: build the response from the opcode rules on whole byte queues.
  function automatic bq_t model(input bq_t ln, input int clen);
    bq_t p, r;
    int n;
    logic [7:0] op;
    p = {};
    r = {};
    if (clen >= 2) begin
      op = ln[0];
      n  = clen - 2;
      for (int j = 0; j < n; j++) p.push_back(ln[1+j]);
      case (op)
        8'h45: r = p;
        8'h52: for (int j = n - 1; j >= 0; j--) r.push_back(p[j]);
        8'h55: foreach (p[j]) r.push_back((p[j] >= 8'h61 && p[j] <= 8'h7A) ? p[j] - 8'h20 : p[j]);
`ifdef UART_CMD_LEN_EN
        8'h4C: begin
          r.push_back(hexc((n / 16) % 16));
          r.push_back(hexc(n % 16));
        end
`endif
        default: r.push_back(8'h3F);
      endcase
      while (r.size() > CAPN) void'(r.pop_back());
    end
    r.push_back(8'h0D);
    r.push_back(8'h0A);
    return r;
  endfunction

  // Loads line_q, fires one command and checks the response against exp_q.
  task automatic run_cmd(input string tag, input int clen, input int poke_at);
    int n, m, t, p0, l0, bound, errs;
    bit seen;
    for (int a = TX; a < 256; a++) ram_wr(a, 8'hEE);
    for (int j = 0; j < clen; j++) ram_wr(j, line_q[j]);
    n = (clen >= 2) ? clen - 2 : 0;
    m = (n > CAPN) ? CAPN : n;
    bound = 5 + 2 * ((m == 0) ? 1 : m);
    p0 = pulses;
    l0 = low_wr;
    cmd_len = 8'(clen);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 1;
    seen = 1'b0;
    while (t <= 600 && !seen) begin
      if (msg_valid) begin
        seen = 1'b1;
      end else begin
        if (t == poke_at) begin
          cmd_len = 8'd3;
          cmd_valid = 1'b1;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        t++;
      end
    end
    check({tag, " msg_valid seen"}, int'(seen), 1);
    if (seen) begin
      check({tag, " latency ok"}, int'(t <= bound), 1);
      check({tag, " msg_len"}, int'(msg_len), exp_q.size());
      repeat (12) @(negedge clk);
      check({tag, " msg_len held"}, int'(msg_len), exp_q.size());
      check({tag, " pulses"}, pulses - p0, 1);
      errs = 0;
      for (int j = 0; j < exp_q.size(); j++) begin
        if (mem[TX+j] !== exp_q[j]) begin
          if (errs == 0) $display("FAIL %s byte %0d: got %0h expected %0h", tag, j, mem[TX+j], exp_q[j]);
          errs++;
        end
      end
      check({tag, " resp bytes wrong"}, errs, 0);
      if (exp_q.size() < 128) check({tag, " no overrun"}, int'(mem[TX+exp_q.size()]), 8'hEE);
      check({tag, " low writes"}, low_wr - l0, 0);
    end
  endtask

  initial begin
    int clen, sel;
    logic [7:0] op;

    vt[0]  = '{line: "Ehi\r",   clen: 4, exp: "hi\r\n",  elen: 4};
    vt[1]  = '{line: "Rabc\n",  clen: 5, exp: "cba\r\n", elen: 5};
    vt[2]  = '{line: "Ua1z\r",  clen: 5, exp: "A1Z\r\n", elen: 5};
    vt[3]  = '{line: "X\r",     clen: 2, exp: "?\r\n",   elen: 3};
    vt[4]  = '{line: "\r",      clen: 1, exp: "\r\n",    elen: 2};
    vt[5]  = '{line: "\r",      clen: 0, exp: "\r\n",    elen: 2};
    vt[6]  = '{line: "E\r",     clen: 2, exp: "\r\n",    elen: 2};
    vt[7]  = '{line: "e1\r",    clen: 3, exp: "?\r\n",   elen: 3};
    vt[8]  = '{line: 64'h55_40_60_7B_0D, clen: 5, exp: 64'h40_60_7B_0D_0A, elen: 5};
    vt[9]  = '{line: "Rx\r",    clen: 3, exp: "x\r\n",   elen: 3};
`ifdef UART_CMD_LEN_EN
    vt[10] = '{line: "Labc\r",  clen: 5, exp: "03\r\n",  elen: 4};
`else
    vt[10] = '{line: "Labc\r",  clen: 5, exp: "?\r\n",   elen: 3};
`endif

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset msg_valid", int'(msg_valid), 0);
    check("reset msg_len", int'(msg_len), 0);
    check("reset addr", int'(addr), 0);
    check("reset din", int'(din), 0);
    check("reset we", int'(we), 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vt[v]) begin
      line_q = str2q(vt[v].line, vt[v].clen);
      exp_q  = str2q(vt[v].exp, vt[v].elen);
      run_cmd($sformatf("vec%0d", v), vt[v].clen, 0);
    end

    // Long echo: payload beyond the response area is dropped.
    line_q = {8'h45};
    for (int j = 0; j < 200; j++) line_q.push_back(8'($urandom_range(8'h20, 8'h7E)));
    line_q.push_back(8'h0D);
    exp_q = model(line_q, 202);
    check("long echo model len", exp_q.size(), 128);
    run_cmd("long echo", 202, 0);

`ifdef UART_CMD_LEN_EN
    line_q = {8'h4C};
    for (int j = 0; j < 26; j++) line_q.push_back(8'h61 + 8'(j));
    line_q.push_back(8'h0D);
    exp_q = {8'h31, 8'h41, 8'h0D, 8'h0A};
    run_cmd("len alphabet", 28, 0);
`endif

    // Reset in the middle of the payload loop.
    line_q = {8'h45};
    for (int j = 0; j < 60; j++) line_q.push_back(8'($urandom_range(8'h20, 8'h7E)));
    line_q.push_back(8'h0D);
    for (int j = 0; j < 62; j++) ram_wr(j, line_q[j]);
    cmd_len = 8'd62;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst we", int'(we), 0);
    check("midrst msg_valid", int'(msg_valid), 0);
    rst = 1'b0;
    begin
      int p0;
      p0 = pulses;
      repeat (200) @(negedge clk);
      check("midrst no pulse", pulses - p0, 0);
    end
    line_q = str2q("Ehi\r", 4);
    exp_q  = str2q("hi\r\n", 4);
    run_cmd("after rst", 4, 0);

    // A second cmd_valid while busy must be ignored.
    line_q = {8'h52};
    for (int j = 0; j < 60; j++) line_q.push_back(8'($urandom_range(8'h20, 8'h7E)));
    line_q.push_back(8'h0A);
    exp_q = model(line_q, 62);
    run_cmd("busy poke", 62, 20);

    for (int it = 0; it < 30; it++) begin
      clen = $urandom_range(0, 128);
      sel  = $urandom_range(0, 5);
      case (sel)
        0: op = 8'h45;
        1: op = 8'h52;
        2: op = 8'h55;
        3: op = 8'h4C;
        4: op = 8'h58;
        default: op = 8'($urandom_range(0, 255));
      endcase
      line_q = {};
      if (clen >= 2) begin
        line_q.push_back(op);
        for (int j = 0; j < clen - 2; j++) begin
          if ($urandom_range(0, 3) == 0) line_q.push_back(8'($urandom_range(0, 255)));
          else line_q.push_back(8'($urandom_range(8'h40, 8'h7F)));
        end
      end
      if (clen >= 1) line_q.push_back(8'h0D);
      exp_q = model(line_q, clen);
      run_cmd($sformatf("rand%0d op=%0h len=%0d", it, op, clen), clen, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
